pp_slot_buf: RTL and testbench

PP_SLOT_BUF -- requirements
Module: pp_slot_buf

---
 rtl/pp_slot_buf.sv | 233 +++++++++++++++++++++++
 tb/tb_pp_slot_buf.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_slot_buf.sv
// Multi-slot packet buffer: collects packets addressed to PP_ID into NSLOTS slots and serves them in order.
// Optional saturating drop/truncation statistics are enabled by defining PP_SLOT_BUF_STATS_EN.
module pp_slot_buf #(
   parameter int PP_ID       = 0,
   parameter int DATA_NBITS  = 256,
   parameter int DEPTH_NBITS = 5,
   parameter int SLOT_NBITS  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pp_valid,
   input  logic [DATA_NBITS-1:0]  pp_data,
   input  logic                   pp_eop,
   input  logic [1:0]             pp_id,
   output logic                   buf_ready,
   output logic                   rd_slot_valid,
   output logic [DEPTH_NBITS:0]   rd_len,
   output logic                   rd_err,
   input  logic                   rd_req,
   input  logic [DEPTH_NBITS-1:0] rd_addr,
   output logic [DATA_NBITS-1:0]  rd_data,
   input  logic                   rd_release,
   output logic                   drop_pulse
`ifdef PP_SLOT_BUF_STATS_EN
   ,
   output logic [15:0]            drop_cnt,
   output logic [15:0]            trunc_cnt
`endif
);

   localparam int NSLOTS  = 1 << SLOT_NBITS;
   localparam int MAX_LEN = 1 << DEPTH_NBITS;
   localparam int CNT_W   = SLOT_NBITS + 1;
   localparam int LEN_W   = DEPTH_NBITS + 1;
   localparam int ADDR_W  = SLOT_NBITS + DEPTH_NBITS;
   localparam logic [1:0] MY_ID = 2'(PP_ID);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DROP  = 2'd2
   } wr_state_t;

   wr_state_t state_reg, state_next;

   logic                  wen;
   logic                  full;
   logic                  room;
   logic                  store;
   logic                  ram_we;
   logic                  commit;
   logic                  drop_evt;
   logic                  release_ok;

   logic [CNT_W-1:0]      count_reg, count_next;
   logic [SLOT_NBITS-1:0] wr_slot_reg, rd_slot_reg;
   logic [LEN_W-1:0]      wr_idx_reg, wr_idx_next;
   logic                  trunc_reg, trunc_next;
   logic [LEN_W-1:0]      commit_len;
   logic                  commit_err;
   logic                  buf_ready_reg;
   logic                  drop_pulse_reg;
   logic [DATA_NBITS-1:0] rd_data_reg;

   logic [LEN_W-1:0]      slot_len_reg [NSLOTS];
   logic                  slot_err_reg [NSLOTS];
   logic [DATA_NBITS-1:0] ram [2**ADDR_W];

   assign wen        = pp_valid && (pp_id == MY_ID);
   assign full       = (count_reg == CNT_W'(NSLOTS));
   assign room       = (wr_idx_reg < LEN_W'(MAX_LEN));
   assign release_ok = rd_release && (count_reg != '0);

   // Write FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Write FSM: next state. The full check uses the registered count only.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (wen && !pp_eop) begin
               state_next = full ? ST_DROP : ST_WRITE;
            end
         end
         ST_WRITE, ST_DROP: begin
            if (wen && pp_eop) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Write FSM: outputs
   always_comb begin
      store    = 1'b0;
      drop_evt = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            store    = wen && !full;
            drop_evt = wen && full && pp_eop;
         end
         ST_WRITE: begin
            store    = wen;
         end
         ST_DROP: begin
            drop_evt = wen && pp_eop;
         end
         default: begin
            store    = 1'b0;
            drop_evt = 1'b0;
         end
      endcase
   end

   assign ram_we     = store && room;
   assign commit     = store && pp_eop;
   assign commit_len = room ? (wr_idx_reg + LEN_W'(1)) : wr_idx_reg;
   assign commit_err = trunc_reg || !room;

   // Beat index saturates at MAX_LEN; extra beats only mark the packet truncated.
   always_comb begin
      wr_idx_next = wr_idx_reg;
      trunc_next  = trunc_reg;
      if (wen && pp_eop) begin
         wr_idx_next = '0;
         trunc_next  = 1'b0;
      end else if (ram_we) begin
         wr_idx_next = wr_idx_reg + LEN_W'(1);
      end else if (store) begin
         trunc_next  = 1'b1;
      end
   end

   always_comb begin
      count_next = count_reg;
      case ({commit, release_ok})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg      <= '0;
         wr_slot_reg    <= '0;
         rd_slot_reg    <= '0;
         wr_idx_reg     <= '0;
         trunc_reg      <= 1'b0;
         buf_ready_reg  <= 1'b1;
         drop_pulse_reg <= 1'b0;
      end else begin
         count_reg      <= count_next;
         wr_idx_reg     <= wr_idx_next;
         trunc_reg      <= trunc_next;
         buf_ready_reg  <= (count_next < CNT_W'(NSLOTS));
         drop_pulse_reg <= drop_evt;
         if (commit) begin
            wr_slot_reg <= wr_slot_reg + SLOT_NBITS'(1);
         end
         if (release_ok) begin
            rd_slot_reg <= rd_slot_reg + SLOT_NBITS'(1);
         end
      end
   end

   // Per-slot length/error descriptors, latched when that slot commits
   generate
      for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_len_reg[gi] <= '0;
               slot_err_reg[gi] <= 1'b0;
            end else if (commit && (wr_slot_reg == SLOT_NBITS'(gi))) begin
               slot_len_reg[gi] <= commit_len;
               slot_err_reg[gi] <= commit_err;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[{wr_slot_reg, wr_idx_reg[DEPTH_NBITS-1:0]}] <= pp_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_reg <= '0;
      end else if (rd_req) begin
         rd_data_reg <= ram[{rd_slot_reg, rd_addr}];
      end
   end

   assign buf_ready     = buf_ready_reg;
   assign drop_pulse    = drop_pulse_reg;
   assign rd_data       = rd_data_reg;
   assign rd_slot_valid = (count_reg != '0);
   // Descriptors of freed slots stay stale, so they are masked while empty.
   assign rd_len        = rd_slot_valid ? slot_len_reg[rd_slot_reg] : '0;
   assign rd_err        = rd_slot_valid ? slot_err_reg[rd_slot_reg] : 1'b0;

`ifdef PP_SLOT_BUF_STATS_EN
   logic [15:0] drop_cnt_reg, trunc_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_reg  <= '0;
         trunc_cnt_reg <= '0;
      end else begin
         if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
         if (commit && commit_err && (trunc_cnt_reg != 16'hFFFF)) begin
            trunc_cnt_reg <= trunc_cnt_reg + 16'd1;
         end
      end
   end

   assign drop_cnt  = drop_cnt_reg;
   assign trunc_cnt = trunc_cnt_reg;
`endif

endmodule

// File: tb/tb_pp_slot_buf.sv
// Randomized self-checking bench for pp_slot_buf against a queue-based packet model.
module tb_pp_slot_buf;
   localparam int PP_ID  = 1;
   localparam int DW     = 64;
   localparam int DN     = 5;
   localparam int SN     = 2;
   localparam int NSLOTS = 4;
   localparam int MAXLEN = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pp_valid = 1'b0;
   logic [DW-1:0] pp_data = '0;
   logic          pp_eop = 1'b0;
   logic [1:0]    pp_id = '0;
   logic          buf_ready;
   logic          rd_slot_valid;
   logic [DN:0]   rd_len;
   logic          rd_err;
   logic          rd_req = 1'b0;
   logic [DN-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_release = 1'b0;
   logic          drop_pulse;
`ifdef PP_SLOT_BUF_STATS_EN
   logic [15:0]   drop_cnt, trunc_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model: committed packets in arrival order; data_q holds their words back to back.
   int            len_q[$];
   bit            err_q[$];
   logic [DW-1:0] data_q[$];
   int            exp_drops = 0;
   int            exp_truncs = 0;

   pp_slot_buf #(.PP_ID(PP_ID), .DATA_NBITS(DW), .DEPTH_NBITS(DN), .SLOT_NBITS(SN)) dut (
      .clk(clk), .rst(rst), .pp_valid(pp_valid), .pp_data(pp_data), .pp_eop(pp_eop),
      .pp_id(pp_id), .buf_ready(buf_ready), .rd_slot_valid(rd_slot_valid), .rd_len(rd_len),
      .rd_err(rd_err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_release(rd_release), .drop_pulse(drop_pulse)
`ifdef PP_SLOT_BUF_STATS_EN
      , .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_head();
      int n;
      n = len_q.pop_front();
      void'(err_q.pop_front());
      for (int i = 0; i < n; i++) void'(data_q.pop_front());
   endtask

   // Sends one packet; rel_beat >= 0 asserts rd_release on that beat.
   task automatic send_pkt(input int n, input int id, input int rel_beat);
      bit acc, drop;
      logic [DW-1:0] w;
      logic [DW-1:0] words[$];
      acc  = (id == PP_ID);
      drop = acc && (len_q.size() == NSLOTS);
      for (int b = 0; b < n; b++) begin
         w          = {$urandom, $urandom};
         pp_valid   = 1'b1;
         pp_data    = w;
         pp_eop     = (b == n - 1);
         pp_id      = 2'(id);
         rd_release = (b == rel_beat);
         if (acc && !drop && b < MAXLEN) words.push_back(w);
         tick();
         if (b == rel_beat && len_q.size() > 0) pop_head();
      end
      pp_valid   = 1'b0;
      pp_eop     = 1'b0;
      rd_release = 1'b0;
      if (acc && !drop) begin
         foreach (words[i]) data_q.push_back(words[i]);
         len_q.push_back(n > MAXLEN ? MAXLEN : n);
         err_q.push_back(n > MAXLEN);
         if (n > MAXLEN) exp_truncs++;
      end
      if (acc && drop) exp_drops++;
      checks++;
      if (drop_pulse !== (acc && drop))
         $display("FAIL drop_pulse n=%0d id=%0d got=%0b want=%0b", n, id, drop_pulse, acc && drop);
      if (drop_pulse !== (acc && drop)) errors++;
      $display("pkt n=%0d id=%0d rel=%0d dropped=%0b", n, id, rel_beat, acc && drop);
   endtask

   // Reads every chunk of the head slot, compares against the model, then releases it.
   task automatic drain_head();
      int n;
      logic [DN:0] exp_len;
      checks++;
      if (rd_slot_valid !== (len_q.size() > 0)) begin
         errors++;
         $display("FAIL drain_valid got=%0b want=%0b", rd_slot_valid, len_q.size() > 0);
      end
      if (len_q.size() == 0) return;
      n = len_q[0];
      exp_len = n[DN:0];
      checks++;
      if (rd_len !== exp_len) begin
         errors++;
         $display("FAIL rd_len got=%0d want=%0d", rd_len, exp_len);
      end
      checks++;
      if (rd_err !== err_q[0]) begin
         errors++;
         $display("FAIL rd_err got=%0b want=%0b", rd_err, err_q[0]);
      end
      for (int a = 0; a < n; a++) begin
         rd_req  = 1'b1;
         rd_addr = a[DN-1:0];
         tick();
         rd_req  = 1'b0;
         checks++;
         if (rd_data !== data_q[a]) begin
            errors++;
            $display("FAIL rd_data addr=%0d got=%h want=%h", a, rd_data, data_q[a]);
         end
      end
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      pop_head();
      checks++;
      if (buf_ready !== (len_q.size() < NSLOTS)) begin
         errors++;
         $display("FAIL buf_ready_after_release got=%0b want=%0b", buf_ready, len_q.size() < NSLOTS);
      end
      $display("read len=%0d left=%0d", n, len_q.size());
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks += 6;
      if (buf_ready !== 1'b1)     begin errors++; $display("FAIL reset_buf_ready got=%0b want=1", buf_ready); end
      if (rd_slot_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", rd_slot_valid); end
      if (rd_len !== '0)          begin errors++; $display("FAIL reset_len got=%0d want=0", rd_len); end
      if (rd_err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%0b want=0", rd_err); end
      if (drop_pulse !== 1'b0)    begin errors++; $display("FAIL reset_drop got=%0b want=0", drop_pulse); end
      if (rd_data !== '0)         begin errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
      rst = 1'b0;
      tick();
      checks++;
      if (buf_ready !== 1'b1 || rd_slot_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got=%0b/%0b want=1/0", buf_ready, rd_slot_valid);
      end
   endtask

   task automatic test_basic();
      send_pkt(3, PP_ID, -1);
      // Out-of-range read must not disturb the head slot.
      rd_req  = 1'b1;
      rd_addr = 5'd20;
      tick();
      rd_req  = 1'b0;
      checks++;
      if (rd_slot_valid !== 1'b1 || rd_len !== 6'd3) begin
         errors++;
         $display("FAIL oob_read valid=%0b len=%0d want 1/3", rd_slot_valid, rd_len);
      end
      drain_head();
   endtask

   task automatic test_foreign_id();
      send_pkt(3, 2, -1);
      send_pkt(1, 0, -1);
      pp_valid = 1'b0;
      pp_id    = 2'(PP_ID);
      pp_eop   = 1'b1;
      tick();
      pp_eop     = 1'b0;
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      checks++;
      if (rd_slot_valid !== 1'b0 || buf_ready !== 1'b1) begin
         errors++;
         $display("FAIL foreign_id valid=%0b ready=%0b want 0/1", rd_slot_valid, buf_ready);
      end
   endtask

   task automatic test_full_drop();
      for (int i = 0; i < NSLOTS; i++) send_pkt($urandom_range(1, 5), PP_ID, -1);
      checks++;
      if (buf_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b want=0", buf_ready); end
      send_pkt(3, PP_ID, -1);
      tick();
      checks++;
      if (drop_pulse !== 1'b0) begin errors++; $display("FAIL drop_once got=%0b want=0", drop_pulse); end
      // Release on the same beat must not rescue a packet arriving while full.
      send_pkt(1, PP_ID, 0);
      checks++;
      if (buf_ready !== 1'b1 || rd_slot_valid !== 1'b1) begin
         errors++;
         $display("FAIL release_no_rescue ready=%0b valid=%0b want 1/1", buf_ready, rd_slot_valid);
      end
`ifdef PP_SLOT_BUF_STATS_EN
      checks++;
      if (drop_cnt !== 16'(exp_drops)) begin
         errors++;
         $display("FAIL drop_cnt got=%0d want=%0d", drop_cnt, exp_drops);
      end
`endif
      while (len_q.size() > 0) drain_head();
   endtask

   task automatic test_truncation();
      send_pkt(40, PP_ID, -1);
`ifdef PP_SLOT_BUF_STATS_EN
      checks++;
      if (trunc_cnt !== 16'(exp_truncs)) begin
         errors++;
         $display("FAIL trunc_cnt got=%0d want=%0d", trunc_cnt, exp_truncs);
      end
`endif
      drain_head();
   endtask

   task automatic test_release_commit();
      send_pkt(2, PP_ID, -1);
      send_pkt(3, PP_ID, -1);
      send_pkt(4, PP_ID, 3);
      checks++;
      if (rd_slot_valid !== 1'b1 || rd_len !== 6'd3 || buf_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_commit valid=%0b len=%0d ready=%0b want 1/3/1", rd_slot_valid, rd_len, buf_ready);
      end
      drain_head();
      drain_head();
      checks++;
      if (rd_slot_valid !== 1'b0) begin errors++; $display("FAIL count_after got=%0b want=0", rd_slot_valid); end
   endtask

   task automatic test_random();
      int r, n, id;
      logic [DN:0] exp_len;
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            n  = (r == 0) ? $urandom_range(30, 40) : $urandom_range(1, 6);
            id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : PP_ID;
            send_pkt(n, id, ($urandom_range(0, 3) == 0) ? n - 1 : -1);
         end else begin
            drain_head();
         end
         checks++;
         if (rd_slot_valid !== (len_q.size() > 0) || buf_ready !== (len_q.size() < NSLOTS)) begin
            errors++;
            $display("FAIL rand_status it=%0d valid=%0b ready=%0b size=%0d", it, rd_slot_valid, buf_ready, len_q.size());
         end
         if (len_q.size() > 0) begin
            exp_len = len_q[0][DN:0];
            checks++;
            if (rd_len !== exp_len) begin
               errors++;
               $display("FAIL rand_len it=%0d got=%0d want=%0d", it, rd_len, exp_len);
            end
         end
      end
      while (len_q.size() > 0) drain_head();
   endtask

   task automatic test_mid_reset();
      send_pkt(2, PP_ID, -1);
      for (int b = 0; b < 2; b++) begin
         pp_valid = 1'b1;
         pp_data  = {$urandom, $urandom};
         pp_eop   = 1'b0;
         pp_id    = 2'(PP_ID);
         tick();
      end
      pp_valid = 1'b0;
      rst = 1'b1;
      #2;
      checks += 5;
      if (buf_ready !== 1'b1)     begin errors++; $display("FAIL mid_rst_ready got=%0b want=1", buf_ready); end
      if (rd_slot_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b want=0", rd_slot_valid); end
      if (rd_len !== '0)          begin errors++; $display("FAIL mid_rst_len got=%0d want=0", rd_len); end
      if (drop_pulse !== 1'b0)    begin errors++; $display("FAIL mid_rst_drop got=%0b want=0", drop_pulse); end
      if (rd_data !== '0)         begin errors++; $display("FAIL mid_rst_data got=%h want=0", rd_data); end
      len_q.delete();
      err_q.delete();
      data_q.delete();
      exp_drops  = 0;
      exp_truncs = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      send_pkt(1, PP_ID, -1);
      drain_head();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_foreign_id();
      test_full_drop();
      test_truncation();
      test_release_commit();
      test_random();
      test_mid_reset();
`ifdef PP_SLOT_BUF_STATS_EN
      checks++;
      if (drop_cnt !== 16'(exp_drops) || trunc_cnt !== 16'(exp_truncs)) begin
         errors++;
         $display("FAIL final_stats got=%0d/%0d want=%0d/%0d", drop_cnt, trunc_cnt, exp_drops, exp_truncs);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
